sd_block_receiver: RTL and testbench
====================================

Name: sd_block_receiver

Overview:
- Parametrised SD-bus serial receiver; successor to the single-byte receiver.
- Armed by `enable`, it waits for a start bit (`SDin`=0) with a bounded timeout, then shifts in a frame of BYTES bytes, MSB first, one bit per clock.
- Each completed byte is streamed out through a valid/ready holding register.
- Sits between the SD pin sampler and the block-buffer/command controller; used for both command responses and data blocks.

Parameters:
- BYTES, 512, frame payload length in bytes (legal range 1..4096).
- TIMEOUT, 255, number of WAIT-state decrements allowed before giving up on the start bit.
- TO_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state and outputs.
- enable, input, 1, starts a frame receive when sampled high in IDLE; ignored in all other states.
- SDin, input, 1, serial data from the SD line (already synchronised).
- byte_out, output, 8, most recent completed byte.
- byte_valid, output, 1, byte_out holds an unconsumed byte.
- byte_ready, input, 1, consumer accepts byte_out when byte_valid & byte_ready.
- busy, output, 1, high whenever state != IDLE.
- done, output, 1, one-cycle pulse at frame end (success or timeout).
- timeout, output, 1, frame ended without a start bit; sticky until the next IDLE->WAIT.
- overrun, output, 1, a byte was overwritten before being consumed; sticky until the next IDLE->WAIT.
- crc_err, output, 1, CRC mismatch; sticky until the next IDLE->WAIT. Tied to 0 when the CRC feature is absent.

Behaviour:
- Reset values: state=IDLE; byte_out=0x00; byte_valid=0; done=0; timeout=0; overrun=0; crc_err=0; all counters=0. Reset mid-frame aborts immediately; no done pulse is produced.
- IDLE: enable=1 -> WAIT. On this transition: timeout counter loads TIMEOUT; timeout, overrun and crc_err clear.
- WAIT, checked in this priority order:
  - SDin=0 -> SHIFT. This is the start bit and is not stored. Bit count=0, byte count=0.
  - Else if the counter is 0 -> DONE and timeout is set.
  - Else the counter decrements.
  - A start bit on the same cycle the counter reaches 0 wins; no timeout is raised.
  - With TIMEOUT=T, the timeout fires after T+1 consecutive WAIT cycles with SDin=1.
- SHIFT:
  - Each clock: shift register <= {sr[6:0], SDin}; bit count increments modulo 8.
  - When bit count=7: the completed byte {sr[6:0], SDin} loads into byte_out and byte_valid=1 on the next edge.
  - On the last bit of byte BYTES-1: -> DONE, or -> CRC when the feature is enabled.
  - Frame length is exactly 8*BYTES SHIFT cycles after the start-bit cycle.
- DONE: done=1 for exactly this one cycle, then -> IDLE. An enable sampled in DONE is ignored.
- Output handshake:
  - A transfer occurs on any edge where byte_valid & byte_ready; byte_valid then clears unless a new byte loads on the same edge.
  - New byte and transfer on the same edge: byte_out takes the new byte, byte_valid stays 1, no overrun.
  - New byte while byte_valid=1 and byte_ready=0: byte_out is overwritten and overrun is set.
  - The block never stalls the serial line.
  - byte_valid may remain high after done; the consumer can drain the last byte while the block is in IDLE.
- Byte count is wide enough for BYTES-1 and wraps only through a new frame start.

Optional Feature:
- Macro: SD_RX_CRC16_EN.
- Defined:
  - After the payload, state CRC shifts 16 further bits: the received CRC16, MSB first. These bits are not emitted on byte_out.
  - A CRC16-CCITT (x^16+x^12+x^5+1, init 0x0000) is computed serially over all payload bits during SHIFT.
  - After the 16th CRC bit -> DONE; crc_err is set in that same transition if received != computed.
- Undefined: no CRC state; crc_err is constant 0; SHIFT goes directly to DONE.

Test Plan:
- BYTES=2: enable, SDin=1 for 3 cycles, start bit 0, then 0xA5, 0x3C with byte_ready=1 -> byte_valid pulses carrying 0xA5 then 0x3C; done one cycle after the last bit; timeout=0, overrun=0.
- TIMEOUT=4: enable with SDin held 1 -> done after exactly 5 WAIT cycles, timeout=1, byte_valid never asserted; next enable clears timeout.
- BYTES=2, byte_ready=0 throughout, bytes 0x12, 0x34 -> byte_out=0x34, byte_valid=1, overrun=1 at done.
- Assert reset during the 5th bit of byte 0 -> all outputs 0 immediately, no done pulse; a new enable then receives 0x5A correctly.
- TIMEOUT=4: start bit arrives on the cycle the counter is 0 -> frame received normally, timeout=0.
- SD_RX_CRC16_EN, BYTES=512, all 0xFF, CRC 0x7FA1 -> crc_err=0. Same frame with CRC 0x7FA0 -> crc_err=1; 512 byte_valid beats in both cases.

Source files
------------

// File: rtl/sd_block_receiver_if.sv
// ---------------------------------------------------------------------------
// sd_block_receiver_if
//   Byte stream handshake between the SD block receiver and its consumer
//   (block buffer or command controller).
//
//   byte_out   : most recent completed byte        (master -> slave)
//   byte_valid : byte_out holds an unconsumed byte (master -> slave)
//   byte_ready : consumer accepts byte_out when byte_valid & byte_ready
//                                                  (slave -> master)
// ---------------------------------------------------------------------------
interface sd_block_receiver_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_out,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/sd_block_receiver.sv
// ---------------------------------------------------------------------------
// sd_block_receiver
//   SD-bus serial block receiver. Armed by enable, waits (bounded) for a start
//   bit on SDin, then shifts in BYTES bytes MSB first, one bit per clock.
//   Each completed byte is presented on a valid/ready holding register; the
//   serial line is never stalled, so an unconsumed byte gets overwritten and
//   flagged as overrun.
//
//   Optional feature, macro SD_RX_CRC16_EN: after the payload, 16 CRC bits are
//   received and compared against a serially computed CRC16-CCITT
//   (x^16+x^12+x^5+1, init 0). Without the macro, crc_err is constant 0.
//
// Parameters
//   BYTES   : payload bytes per frame (1..4096)
//   TIMEOUT : WAIT-state decrements allowed before giving up on the start bit
//   TO_W    : timeout counter width, must hold TIMEOUT
//
// Ports
//   clock    : rising-edge clock
//   reset    : asynchronous, active-high; clears all state and outputs
//   enable   : starts a frame receive when sampled high in IDLE
//   SDin     : synchronised serial data
//   stream   : byte_out / byte_valid / byte_ready handshake (master side)
//   busy     : state != IDLE
//   done     : one-cycle pulse at frame end (success or timeout)
//   timeout  : no start bit seen; sticky until next arm
//   overrun  : byte overwritten before being consumed; sticky until next arm
//   crc_err  : CRC mismatch; sticky until next arm
// ---------------------------------------------------------------------------
module sd_block_receiver #(
  parameter int BYTES   = 512,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       SDin,
  sd_block_receiver_if.master        stream,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic                       overrun,
  output logic                       crc_err
);

  localparam int              BC_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
`ifdef SD_RX_CRC16_EN
    S_CRC,
`endif
    S_DONE
  } state_t;

  state_t          state, state_next;
  logic [TO_W-1:0] to_cnt;
  logic [2:0]      bit_cnt;
  logic [BC_W-1:0] byte_cnt;
  logic [6:0]      sr;          // first seven bits of the byte in flight
  logic [7:0]      new_byte;

  // FSM control strobes
  logic arm;          // IDLE -> WAIT
  logic start_shift;  // start bit seen
  logic to_dec;       // WAIT counter decrement
  logic set_to;       // WAIT gave up
  logic load_byte;    // last bit of a byte is on SDin this cycle

  assign new_byte = {sr, SDin};

`ifdef SD_RX_CRC16_EN
  logic [15:0] crc;       // computed over payload bits
  logic [15:0] crc_rx;    // received CRC bits
  logic [3:0]  crc_cnt;
  logic        crc_last;  // 16th CRC bit is on SDin this cycle
  logic        crc_fb;
  logic [15:0] crc_next;

  assign crc_fb   = crc[15] ^ SDin;
  assign crc_next = {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // -------------------------------------------------------------------------
  // Next-state and control strobes
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    arm         = 1'b0;
    start_shift = 1'b0;
    to_dec      = 1'b0;
    set_to      = 1'b0;
    load_byte   = 1'b0;
`ifdef SD_RX_CRC16_EN
    crc_last    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_next = S_WAIT;
          arm        = 1'b1;
        end
      end
      S_WAIT: begin
        // Start bit has priority over an expiring counter.
        if (!SDin) begin
          state_next  = S_SHIFT;
          start_shift = 1'b1;
        end else if (to_cnt == '0) begin
          state_next = S_DONE;
          set_to     = 1'b1;
        end else begin
          to_dec = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bit_cnt == 3'd7) begin
          load_byte = 1'b1;
          if (byte_cnt == LAST_BYTE) begin
`ifdef SD_RX_CRC16_EN
            state_next = S_CRC;
`else
            state_next = S_DONE;
`endif
          end
        end
      end
`ifdef SD_RX_CRC16_EN
      S_CRC: begin
        if (crc_cnt == 4'd15) begin
          state_next = S_DONE;
          crc_last   = 1'b1;
        end
      end
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // -------------------------------------------------------------------------
  // Datapath: counters, shift register, output holding register, flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt            <= '0;
      bit_cnt           <= '0;
      byte_cnt          <= '0;
      sr                <= '0;
      stream.byte_out   <= '0;
      stream.byte_valid <= 1'b0;
      timeout           <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      if (arm) begin
        to_cnt  <= TO_W'(TIMEOUT);
        timeout <= 1'b0;
        overrun <= 1'b0;
      end else if (to_dec) begin
        to_cnt <= to_cnt - TO_W'(1);
      end

      if (set_to) timeout <= 1'b1;

      if (start_shift) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end

      if (state == S_SHIFT) begin
        sr      <= {sr[5:0], SDin};
        bit_cnt <= bit_cnt + 3'd1;
        // Byte count saturates at the last byte; only a new start bit clears it.
        if (bit_cnt == 3'd7 && byte_cnt != LAST_BYTE)
          byte_cnt <= byte_cnt + BC_W'(1);
      end

      // Holding register: a new byte always wins; a simultaneous transfer
      // simply keeps valid high without counting as an overrun.
      if (load_byte) begin
        stream.byte_out   <= new_byte;
        stream.byte_valid <= 1'b1;
        if (stream.byte_valid && !stream.byte_ready) overrun <= 1'b1;
      end else if (stream.byte_valid && stream.byte_ready) begin
        stream.byte_valid <= 1'b0;
      end
    end
  end

`ifdef SD_RX_CRC16_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc     <= '0;
      crc_rx  <= '0;
      crc_cnt <= '0;
      crc_err <= 1'b0;
    end else begin
      if (arm) crc_err <= 1'b0;

      if (start_shift) begin
        crc     <= '0;
        crc_cnt <= '0;
      end

      if (state == S_SHIFT) crc <= crc_next;

      if (state == S_CRC) begin
        crc_rx  <= {crc_rx[14:0], SDin};
        crc_cnt <= crc_cnt + 4'd1;
      end

      if (crc_last && ({crc_rx[14:0], SDin} != crc)) crc_err <= 1'b1;
    end
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_block_receiver.sv
// ---------------------------------------------------------------------------
// tb_sd_block_receiver
//   Directed bench for sd_block_receiver with BYTES=2, TIMEOUT=4. Inputs are
//   driven and outputs sampled 1 time unit after each rising edge. With
//   SD_RX_CRC16_EN defined, a second instance (BYTES=512) receives all-0xFF
//   blocks with good and bad CRCs.
// ---------------------------------------------------------------------------
module tb_sd_block_receiver;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic SDin;
  logic busy, done, timeout, overrun, crc_err;

  int n_cmp = 0;
  int n_bad = 0;

  sd_block_receiver_if bus ();

  sd_block_receiver #(.BYTES(2), .TIMEOUT(4), .TO_W(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .SDin    (SDin),
    .stream  (bus.master),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .overrun (overrun),
    .crc_err (crc_err)
  );

`ifdef SD_RX_CRC16_EN
  logic enable2, SDin2;
  logic busy2, done2, timeout2, overrun2, crc_err2;

  sd_block_receiver_if bus2 ();

  sd_block_receiver #(.BYTES(512), .TIMEOUT(255), .TO_W(8)) dut_crc (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable2),
    .SDin    (SDin2),
    .stream  (bus2.master),
    .busy    (busy2),
    .done    (done2),
    .timeout (timeout2),
    .overrun (overrun2),
    .crc_err (crc_err2)
  );
`endif

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      SDin = b[i];
      tick();
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    SDin = 1'b1;
    bus.byte_ready = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, timeout, overrun, crc_err, bus.byte_valid} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, timeout, overrun, crc_err, bus.byte_valid});
    end
    n_cmp++;
    if (bus.byte_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_byte_out: got %h want 00", bus.byte_out);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_frame();
    bus.byte_ready = 1'b1;
    enable = 1'b1;
    SDin = 1'b1;
    tick();                       // IDLE -> WAIT
    enable = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_busy: got %b want 1", busy);
    end
    tick(); tick(); tick();       // three idle-line WAIT cycles
    SDin = 1'b0;
    tick();                       // start bit
    shift_byte(8'hA5);
    n_cmp++;
    if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'hA5 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_byte0: got v=%b d=%h done=%b want v=1 d=a5 done=0",
               bus.byte_valid, bus.byte_out, done);
    end
    shift_byte(8'h3C);
    n_cmp++;
    if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'h3C || done !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_byte1: got v=%b d=%h done=%b want v=1 d=3c done=1",
               bus.byte_valid, bus.byte_out, done);
    end
    n_cmp++;
    if ({timeout, overrun, crc_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL frame_flags: got to/ov/crc=%b want 000", {timeout, overrun, crc_err});
    end
    tick();
    n_cmp++;
    if ({busy, done, bus.byte_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL frame_end: got busy/done/valid=%b want 000",
               {busy, done, bus.byte_valid});
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_timeout();
    logic seen_valid;
    seen_valid = 1'b0;
    bus.byte_ready = 1'b1;
    enable = 1'b1;
    SDin = 1'b1;
    tick();                       // IDLE -> WAIT
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen_valid |= bus.byte_valid;
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_early_done: wait cycle %0d got done=%b want 0", k + 1, done);
      end
    end
    tick();                       // fifth WAIT cycle expires
    seen_valid |= bus.byte_valid;
    n_cmp++;
    if (done !== 1'b1 || timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_fire: got done=%b timeout=%b want 1 1", done, timeout);
    end
    tick();
    seen_valid |= bus.byte_valid;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_sticky: got busy=%b done=%b timeout=%b want 0 0 1",
               busy, done, timeout);
    end
    n_cmp++;
    if (seen_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_no_valid: got %b want 0", seen_valid);
    end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n_cmp++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_clear: got timeout=%b busy=%b want 0 1", timeout, busy);
    end
    for (int k = 0; k < 6; k++) tick();  // let it expire and return to IDLE
  endtask

  // -------------------------------------------------------------------------
  task automatic test_overrun();
    bus.byte_ready = 1'b0;
    enable = 1'b1;
    SDin = 1'b1;
    tick();
    enable = 1'b0;
    SDin = 1'b0;
    tick();                       // start bit on first WAIT cycle
    shift_byte(8'h12);
    n_cmp++;
    if (bus.byte_out !== 8'h12 || bus.byte_valid !== 1'b1 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_byte0: got d=%h v=%b ov=%b want 12 1 0",
               bus.byte_out, bus.byte_valid, overrun);
    end
    shift_byte(8'h34);
    n_cmp++;
    if (bus.byte_out !== 8'h34 || bus.byte_valid !== 1'b1 || overrun !== 1'b1 ||
        done !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_done: got d=%h v=%b ov=%b done=%b want 34 1 1 1",
               bus.byte_out, bus.byte_valid, overrun, done);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || bus.byte_valid !== 1'b1 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_hold: got busy=%b v=%b ov=%b want 0 1 1",
               busy, bus.byte_valid, overrun);
    end
    bus.byte_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.byte_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_drain: got v=%b want 0", bus.byte_valid);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_midframe();
    logic seen_done;
    seen_done = 1'b0;
    bus.byte_ready = 1'b1;
    enable = 1'b1;
    SDin = 1'b1;
    tick();
    enable = 1'b0;
    SDin = 1'b0;
    tick();                       // start bit
    SDin = 1'b1; tick();
    SDin = 1'b0; tick();
    SDin = 1'b1; tick();
    SDin = 1'b1; tick();
    SDin = 1'b0;                  // fifth bit in progress
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, timeout, overrun, crc_err, bus.byte_valid} !== 6'b0 ||
        bus.byte_out !== 8'h00) begin
      n_bad++;
      $display("FAIL midreset_clear: got flags=%b d=%h want 000000 00",
               {busy, done, timeout, overrun, crc_err, bus.byte_valid}, bus.byte_out);
    end
    tick();
    seen_done |= done;
    reset = 1'b0;
    SDin = 1'b1;
    tick();
    seen_done |= done;
    tick();
    seen_done |= done;
    n_cmp++;
    if (seen_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_no_done: got done_seen=%b busy=%b want 0 0", seen_done, busy);
    end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    SDin = 1'b0;
    tick();
    shift_byte(8'h5A);
    n_cmp++;
    if (bus.byte_out !== 8'h5A || bus.byte_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_recv: got d=%h v=%b want 5a 1", bus.byte_out, bus.byte_valid);
    end
    shift_byte(8'h00);
    n_cmp++;
    if (done !== 1'b1 || bus.byte_out !== 8'h00 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_done: got done=%b d=%h ov=%b want 1 00 0",
               done, bus.byte_out, overrun);
    end
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_start_on_zero();
    bus.byte_ready = 1'b1;
    enable = 1'b1;
    SDin = 1'b1;
    tick();                       // counter loads 4
    enable = 1'b0;
    for (int k = 0; k < 4; k++) tick();  // counter now 0
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_pre: got busy=%b done=%b to=%b want 1 0 0", busy, done, timeout);
    end
    SDin = 1'b0;
    tick();                       // start bit wins over expiry
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_start: got busy=%b done=%b to=%b want 1 0 0", busy, done, timeout);
    end
    shift_byte(8'hC3);
    n_cmp++;
    if (bus.byte_out !== 8'hC3 || bus.byte_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_byte0: got d=%h v=%b want c3 1", bus.byte_out, bus.byte_valid);
    end
    shift_byte(8'h81);
    n_cmp++;
    if (bus.byte_out !== 8'h81 || done !== 1'b1 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_done: got d=%h done=%b to=%b want 81 1 0",
               bus.byte_out, done, timeout);
    end
  endtask

  // -------------------------------------------------------------------------
  // Enable held high through DONE must not re-arm until IDLE.
  task automatic test_back_to_back();
    SDin = 1'b1;
    enable = 1'b1;
    tick();                       // DONE -> IDLE, enable ignored
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_done_ignored: got busy=%b want 0", busy);
    end
    tick();                       // IDLE -> WAIT
    enable = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_rearm: got busy=%b to=%b want 1 0", busy, timeout);
    end
    for (int k = 0; k < 6; k++) tick();
    n_cmp++;
    if (busy !== 1'b0 || timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_expire: got busy=%b to=%b want 0 1", busy, timeout);
    end
  endtask

`ifdef SD_RX_CRC16_EN
  task automatic test_crc(input logic [15:0] crc_val, input logic exp_err);
    int beats;
    logic [15:0] crc_bits;
    beats = 0;
    crc_bits = crc_val;
    bus2.byte_ready = 1'b1;
    enable2 = 1'b1;
    SDin2 = 1'b1;
    tick();
    enable2 = 1'b0;
    SDin2 = 1'b0;
    tick();
    for (int k = 0; k < 4096; k++) begin
      SDin2 = 1'b1;
      tick();
      if (bus2.byte_valid) beats++;
    end
    for (int i = 15; i >= 0; i--) begin
      SDin2 = crc_bits[i];
      tick();
      if (bus2.byte_valid) beats++;
    end
    n_cmp++;
    if (done2 !== 1'b1 || crc_err2 !== exp_err) begin
      n_bad++;
      $display("FAIL crc_%h: got done=%b crc_err=%b want 1 %b", crc_val, done2, crc_err2, exp_err);
    end
    n_cmp++;
    if (beats != 512) begin
      n_bad++;
      $display("FAIL crc_beats_%h: got %0d want 512", crc_val, beats);
    end
    SDin2 = 1'b1;
    tick();
  endtask
`endif

  // -------------------------------------------------------------------------
  initial begin
`ifdef SD_RX_CRC16_EN
    enable2 = 1'b0;
    SDin2 = 1'b1;
    bus2.byte_ready = 1'b0;
`endif
    test_reset();
    test_frame();
    test_timeout();
    test_overrun();
    test_reset_midframe();
    test_start_on_zero();
    test_back_to_back();
`ifdef SD_RX_CRC16_EN
    test_crc(16'h7FA1, 1'b0);
    test_crc(16'h7FA0, 1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
